// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug halt/read responder.
// Holds the controller state encoding and the register-0 read filter.
package dbg_pkg;

   localparam int DBG_REG_W        = 5;
   localparam int DBG_DATA_W       = 32;
   localparam int DBG_DRAIN_CYCLES = 4;

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      DRAIN  = 3'd1,
      HALTED = 3'd2,
      READ   = 3'd3,
      RESP   = 3'd4
   } dbg_state_e;

   // Register 0 is hardwired to zero regardless of what the port returns.
   function automatic logic [DBG_DATA_W-1:0] rd_filter(
      input logic [DBG_REG_W-1:0]  addr,
      input logic [DBG_DATA_W-1:0] data
   );
      if (addr == {DBG_REG_W{1'b0}}) begin
         return {DBG_DATA_W{1'b0}};
      end else begin
         return data;
      end
   endfunction

endpackage

// File: rtl/dbg_cycle_counter.sv
// Enable-gated free-running counter with asynchronous active-low clear.
// Wraps naturally from all-ones back to zero.
module dbg_cycle_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_r;

   // Count register: advances only while enabled.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_r <= {CNT_W{1'b0}};
      end else if (en) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/dbg_state_responder.sv
// Debug responder: halts and drains the pipeline, serves register reads over
// valid/ready handshakes, resumes on request, and counts non-stalled cycles.
module dbg_state_responder
   import dbg_pkg::*;
#(
   parameter int DRAIN_CYCLES = DBG_DRAIN_CYCLES,
   parameter int CNT_W        = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  dbg_halt_req,
   input  logic                  dbg_resume,
   input  logic                  dbg_rd_valid,
   output logic                  dbg_rd_ready,
   input  logic [DBG_REG_W-1:0]  dbg_rd_addr,
   output logic                  dbg_rsp_valid,
   input  logic                  dbg_rsp_ready,
   output logic [DBG_DATA_W-1:0] dbg_rsp_data,
   output logic                  proc_stall,
   output logic                  rf_dbg_sel,
   output logic [DBG_REG_W-1:0]  rf_dbg_addr,
   input  logic [DBG_DATA_W-1:0] rf_dbg_data,
   output logic                  halted,
   output logic [CNT_W-1:0]      cycle_count
);

   localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DRAIN_CYCLES - 1);

   dbg_state_e              state_r, state_s;
   logic [DRN_W-1:0]        drain_cnt_r, drain_cnt_s;
   logic                    proc_stall_r, halted_r, rd_ready_r, rsp_valid_r, rf_sel_r;
   logic [DBG_REG_W-1:0]    rf_addr_r;
   logic [DBG_DATA_W-1:0]   rsp_data_r;

   // Next-state and drain-counter logic.
   always_comb begin
      state_s     = state_r;
      drain_cnt_s = drain_cnt_r;
      case (state_r)
         RUN: begin
            if (dbg_halt_req) begin
               state_s     = DRAIN;
               drain_cnt_s = DRN_INIT;
            end else begin
               state_s = RUN;
            end
         end
         DRAIN: begin
            if (drain_cnt_r == {DRN_W{1'b0}}) begin
               state_s = HALTED;
            end else begin
               drain_cnt_s = drain_cnt_r - DRN_W'(1);
            end
         end
         HALTED: begin
            // A pending read takes priority over a coincident resume.
            if (dbg_rd_valid) begin
               state_s = READ;
            end else if (dbg_resume) begin
               state_s = RUN;
            end else begin
               state_s = HALTED;
            end
         end
         READ:    state_s = RESP;
         RESP: begin
            if (dbg_rsp_ready) begin
               state_s = HALTED;
            end else begin
               state_s = RESP;
            end
         end
         default: state_s = RUN;
      endcase
   end

   // State, drain counter and registered outputs (decoded from next state).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= RUN;
         drain_cnt_r  <= {DRN_W{1'b0}};
         proc_stall_r <= 1'b0;
         halted_r     <= 1'b0;
         rd_ready_r   <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rf_sel_r     <= 1'b0;
         rf_addr_r    <= {DBG_REG_W{1'b0}};
         rsp_data_r   <= {DBG_DATA_W{1'b0}};
      end else begin
         state_r      <= state_s;
         drain_cnt_r  <= drain_cnt_s;
         proc_stall_r <= (state_s != RUN);
         halted_r     <= (state_s == HALTED) || (state_s == READ) || (state_s == RESP);
         rd_ready_r   <= (state_s == HALTED);
         rsp_valid_r  <= (state_s == RESP);
         rf_sel_r     <= (state_s == READ);
         rf_addr_r    <= (state_s == READ) ? dbg_rd_addr : {DBG_REG_W{1'b0}};
         rsp_data_r   <= (state_r == READ) ? rd_filter(rf_addr_r, rf_dbg_data) : rsp_data_r;
      end
   end

   dbg_cycle_counter #(.CNT_W(CNT_W)) u_cycle_counter (
      .clock (clock),
      .reset (reset),
      .en    (state_r == RUN),
      .count (cycle_count)
   );

   assign proc_stall    = proc_stall_r;
   assign halted        = halted_r;
   assign dbg_rd_ready  = rd_ready_r;
   assign dbg_rsp_valid = rsp_valid_r;
   assign dbg_rsp_data  = rsp_data_r;
   assign rf_dbg_sel    = rf_sel_r;
   assign rf_dbg_addr   = rf_addr_r;

endmodule

// File: tb/tb_dbg_state_responder.sv
// Randomized scoreboard bench for dbg_state_responder: a behavioural regfile
// and cycle-count model supply expectations; a negedge monitor checks responses.
module tb_dbg_state_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        dbg_halt_req, dbg_resume, dbg_rd_valid, dbg_rd_ready;
   logic [4:0]  dbg_rd_addr;
   logic        dbg_rsp_valid, dbg_rsp_ready;
   logic [31:0] dbg_rsp_data;
   logic        proc_stall, rf_dbg_sel, halted;
   logic [4:0]  rf_dbg_addr;
   logic [31:0] rf_dbg_data;
   logic [31:0] cycle_count;

   logic [31:0] mem [32];
   logic [31:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;
   int          exp_cnt = 0;
   bit          model_run = 1'b0;
   bit          held = 1'b0;
   logic [31:0] held_data;

   always #5 clock = ~clock;

   // Behavioural regfile: garbage whenever the debug mux is not selected.
   assign rf_dbg_data = rf_dbg_sel ? mem[rf_dbg_addr] : 32'hDEAD_BEEF;

   dbg_state_responder #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .dbg_halt_req  (dbg_halt_req),
      .dbg_resume    (dbg_resume),
      .dbg_rd_valid  (dbg_rd_valid),
      .dbg_rd_ready  (dbg_rd_ready),
      .dbg_rd_addr   (dbg_rd_addr),
      .dbg_rsp_valid (dbg_rsp_valid),
      .dbg_rsp_ready (dbg_rsp_ready),
      .dbg_rsp_data  (dbg_rsp_data),
      .proc_stall    (proc_stall),
      .rf_dbg_sel    (rf_dbg_sel),
      .rf_dbg_addr   (rf_dbg_addr),
      .rf_dbg_data   (rf_dbg_data),
      .halted        (halted),
      .cycle_count   (cycle_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: the model counts every edge taken while the pipeline runs.
   task automatic step();
      @(posedge clock);
      if (model_run) exp_cnt++;
      #1;
   endtask

   // Response monitor: pops expectations on handshakes, checks hold stability.
   always @(negedge clock) begin
      if (reset === 1'b1 && dbg_rsp_valid === 1'b1) begin
         if (held) check("rsp_stable", {32'd0, dbg_rsp_data}, {32'd0, held_data});
         if (dbg_rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected actual=%0h required=none", dbg_rsp_data);
            end else begin
               check("rsp_data", {32'd0, dbg_rsp_data}, {32'd0, exp_q.pop_front()});
            end
            held = 1'b0;
         end else begin
            held      = 1'b1;
            held_data = dbg_rsp_data;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic randomize_mem(input bit plant_r3);
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'hFFFF_FFFF;
      if (plant_r3) mem[3] = 32'h0000_00AB;
   endtask

   task automatic do_read(input logic [4:0] addr, input int hold, input bit with_resume);
      check("rd_ready_before", {63'd0, dbg_rd_ready}, 64'd1);
      dbg_rd_addr  = addr;
      dbg_rd_valid = 1'b1;
      dbg_resume   = with_resume;
      exp_q.push_back((addr == 5'd0) ? 32'd0 : mem[addr]);
      step();
      dbg_rd_valid = 1'b0;
      dbg_resume   = 1'b0;
      dbg_rd_addr  = 5'($urandom);
      check("read_rd_ready", {63'd0, dbg_rd_ready}, 64'd0);
      check("read_rf_sel", {63'd0, rf_dbg_sel}, 64'd1);
      check("read_rf_addr", {59'd0, rf_dbg_addr}, {59'd0, addr});
      check("read_rsp_valid", {63'd0, dbg_rsp_valid}, 64'd0);
      step();
      check("resp_valid_latency", {63'd0, dbg_rsp_valid}, 64'd1);
      check("resp_rf_sel", {63'd0, rf_dbg_sel}, 64'd0);
      repeat (hold) step();
      dbg_rsp_ready = 1'b1;
      step();
      dbg_rsp_ready = 1'b0;
      check("post_rsp_valid", {63'd0, dbg_rsp_valid}, 64'd0);
      check("post_rd_ready", {63'd0, dbg_rd_ready}, 64'd1);
      check("post_halted", {63'd0, halted}, 64'd1);
      check("post_stall", {63'd0, proc_stall}, 64'd1);
   endtask

   // Run n cycles, then raise halt so it is sampled on the n-th edge.
   task automatic run_and_halt(input int n);
      repeat (n - 1) step();
      check("run_stall", {63'd0, proc_stall}, 64'd0);
      check("run_halted", {63'd0, halted}, 64'd0);
      check("run_count", {32'd0, cycle_count}, {32'd0, 32'(exp_cnt)});
      dbg_halt_req = 1'b1;
      step();
      model_run    = 1'b0;
      dbg_halt_req = 1'($urandom_range(0, 1));
      check("drain_stall", {63'd0, proc_stall}, 64'd1);
      check("drain_halted", {63'd0, halted}, 64'd0);
      check("drain_rd_ready", {63'd0, dbg_rd_ready}, 64'd0);
      repeat (3) step();
      check("drain_late_halted", {63'd0, halted}, 64'd0);
      step();
      dbg_halt_req = 1'b0;
      check("halted_set", {63'd0, halted}, 64'd1);
      check("halted_rd_ready", {63'd0, dbg_rd_ready}, 64'd1);
      check("halted_count", {32'd0, cycle_count}, {32'd0, 32'(exp_cnt)});
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      dbg_halt_req = 1'b0; dbg_resume = 1'b0; dbg_rd_valid = 1'b0;
      dbg_rd_addr = 5'd0; dbg_rsp_ready = 1'b0;
      randomize_mem(1'b1);
      #12;
      check("rst_stall", {63'd0, proc_stall}, 64'd0);
      check("rst_halted", {63'd0, halted}, 64'd0);
      check("rst_rd_ready", {63'd0, dbg_rd_ready}, 64'd0);
      check("rst_rsp_valid", {63'd0, dbg_rsp_valid}, 64'd0);
      check("rst_rf_sel", {63'd0, rf_dbg_sel}, 64'd0);
      check("rst_count", {32'd0, cycle_count}, 64'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      exp_cnt   = 0;
      model_run = 1'b1;

      for (int s = 0; s < 3; s++) begin
         run_and_halt((s == 0) ? 10 : $urandom_range(3, 15));
         randomize_mem(s == 0);
         if (s == 0) begin
            do_read(5'd3, 3, 1'b0);
            do_read(5'd0, 1, 1'b0);
            do_read(5'd7, 0, 1'b1);
         end
         for (int r = 0; r < 4; r++) begin
            do_read(5'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         end
         dbg_resume = 1'b1;
         step();
         model_run  = 1'b1;
         dbg_resume = 1'b0;
         check("resume_halted", {63'd0, halted}, 64'd0);
         check("resume_stall", {63'd0, proc_stall}, 64'd0);
         check("resume_count", {32'd0, cycle_count}, {32'd0, 32'(exp_cnt)});
         repeat ($urandom_range(1, 6)) step();
         check("rerun_count", {32'd0, cycle_count}, {32'd0, 32'(exp_cnt)});
      end

      // Reset asserted while a response is pending.
      run_and_halt(4);
      dbg_rd_addr  = 5'd9;
      dbg_rd_valid = 1'b1;
      step();
      dbg_rd_valid = 1'b0;
      step();
      check("pre_rst_rsp_valid", {63'd0, dbg_rsp_valid}, 64'd1);
      #3 reset = 1'b0;
      #1;
      check("async_rsp_valid", {63'd0, dbg_rsp_valid}, 64'd0);
      check("async_halted", {63'd0, halted}, 64'd0);
      check("async_stall", {63'd0, proc_stall}, 64'd0);
      check("async_count", {32'd0, cycle_count}, 64'd0);
      exp_q.delete();
      @(posedge clock);
      #1 reset = 1'b1;
      exp_cnt   = 0;
      model_run = 1'b1;
      repeat (7) step();
      check("post_rst_count", {32'd0, cycle_count}, {32'd0, 32'(exp_cnt)});
      check("post_rst_stall", {63'd0, proc_stall}, 64'd0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
